vector_chunk_streamer: RTL and testbench
========================================

Name: vector_chunk_streamer

Overview:
- Captures NCHAN input vectors of VEC_LEN elements (NBITS each) on a start pulse.
- Streams each captured vector as NCHUNKS flat chunks, all channels in lockstep, over a valid/ready handshake.
- Generalises fixed two-half packing to arbitrary chunk count, channel count and back-pressure.
- Sits between HLS-style array ports and the downstream wide-word consumer (BRAM writer / accelerator input).

Parameters:
- NBITS, 8, element width in bits.
- VEC_LEN, 1024, elements per vector.
- NCHAN, 2, number of vectors streamed in parallel.
- NCHUNKS, 2, chunks per vector. VEC_LEN % NCHUNKS must be 0; elaboration error otherwise.
- Derived CHUNK_ELEMS = VEC_LEN/NCHUNKS; CW = CHUNK_ELEMS*NBITS; IW = $clog2(NCHUNKS) with minimum 1.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, reset. Synchronous, active-high.
- vec_in, input, [NCHAN][VEC_LEN][NBITS] unpacked, source vectors; sampled only on an accepted start.
- start, input, 1, start request; accepted only in IDLE.
- busy, output, 1, high in LOAD and STREAM.
- chunk_out, output, [NCHAN][CW], current chunk of each channel.
- chunk_idx, output, IW, index of the chunk on chunk_out.
- out_valid, output, 1, chunk_out/chunk_idx/last are valid.
- out_ready, input, 1, consumer accepts when out_valid && out_ready.
- last, output, 1, high with chunk NCHUNKS-1.
- done, output, 1, one-cycle pulse after the final chunk handshake.

Behaviour:
- Reset values: busy=0, out_valid=0, last=0, done=0, chunk_idx=0, chunk_out=0; state=IDLE.
- Packing rule:
  - Element k of a vector sits at flat bits [(k+1)*NBITS-1 : k*NBITS].
  - Chunk c of a channel is flat bits [(c+1)*CW-1 : c*CW], so chunk 0 holds elements 0..CHUNK_ELEMS-1.
- IDLE:
  - On start=1, all NCHAN vectors are registered into capture storage; go to LOAD.
  - start in any other state is ignored; there is no queueing.
- LOAD (1 cycle):
  - chunk_idx=0, out_valid=1, last=(NCHUNKS==1); go to STREAM.
  - Latency: start sampled at edge t gives out_valid=1 after edge t+1.
- STREAM:
  - Without a handshake, chunk_out, chunk_idx and last hold stable.
  - A handshake on a chunk with chunk_idx < NCHUNKS-1 increments chunk_idx next cycle, recomputes last and keeps out_valid=1. Gap-free streaming follows when out_ready is held at 1.
  - A handshake with last=1 clears out_valid and last and pulses done next cycle; go to IDLE.
- done and a new start on the same cycle: the start is accepted, because the state is already IDLE.
- chunk_out is registered, not combinational from vec_in. Changes on vec_in after capture have no effect on the stream.
- chunk_out keeps its last value in IDLE; consumers qualify it with out_valid.
- rst in any state aborts immediately: all outputs return to reset values next cycle, no done pulse, and capture storage contents are don't-care.
- NCHUNKS=1: a single beat with last=1 and chunk_idx=0.

Decomposition:
- Package vec_stream_pkg holds:
  - the state enum typedef (IDLE, LOAD, STREAM);
  - function idx_width(n) returning max(1,$clog2(n));
  - a parameter-check macro/function.
- Sub-module vector_flattener (combinational, parametrised NBITS/VEC_LEN) converts the unpacked array to a flat word. It is instantiated once per channel on the capture path.
- The chunk select is an indexed part-select of the captured flat word by chunk_idx.

Test Plan:
- Common bench setup: NBITS=8, VEC_LEN=8, NCHUNKS=4, NCHAN=2; ch0[k]=k+1, ch1[k]=0x10+k.
- Basic stream, start with out_ready=1 → beats 0..3: ch0 = 0x0201, 0x0403, 0x0605, 0x0807; ch1 = 0x1110, 0x1312, 0x1514, 0x1716. last only on idx 3; done one cycle after beat 3; out_valid first high 2 edges after start.
- Back-pressure, out_ready low for 5 cycles on idx 1 → chunk_out=0x0403 and idx=1 stable throughout; no skipped or duplicated beats.
- Capture isolation, vec_in changed to all 0xFF one cycle after start → stream still 0x0201..0x0807.
- Ignored start, start pulsed during STREAM idx 2 → no restart. Start on the done cycle → new stream begins; idx 0 valid after 2 edges.
- Mid-stream reset, rst at idx 2 → next cycle out_valid=0, busy=0, done never pulses. A following start streams normally from idx 0.
- Degenerate, NCHUNKS=1 → single beat: ch0 = 0x0807060504030201, last=1, done next cycle.

Source files
------------

// File: rtl/vec_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_stream_pkg
//  Description : Shared types and elaboration helpers for vector_chunk_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } stream_state_t;

    // Index width never drops below one bit so a single-chunk build still has a port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit chunk_cfg_ok(input int vec_len, input int nchunks);
        return (nchunks > 0) && (vec_len > 0) && ((vec_len % nchunks) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_flattener.sv
`default_nettype none
// ============================================================================
//  Module      : vector_flattener
//  Description : Packs an unpacked element array into one flat word, element 0 in the LSBs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_flattener #(
    parameter int NBITS   = 8,
    parameter int VEC_LEN = 1024
) (
    input  logic [NBITS-1:0]         vec [VEC_LEN],
    output logic [VEC_LEN*NBITS-1:0] flat
);

    for (genvar k = 0; k < VEC_LEN; k++) begin : g_elem
        assign flat[k*NBITS +: NBITS] = vec[k];
    end

endmodule
`default_nettype wire

// File: rtl/vector_chunk_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_chunk_streamer
//  Description : Captures NCHAN vectors on start and streams them as NCHUNKS
//                registered chunks per channel over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_chunk_streamer
    import vec_stream_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int VEC_LEN = 1024,
    parameter int NCHAN   = 2,
    parameter int NCHUNKS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NBITS-1:0]                     vec_in [NCHAN][VEC_LEN],
    input  logic                                 start,
    output logic                                 busy,
    output logic [(VEC_LEN/NCHUNKS)*NBITS-1:0]   chunk_out [NCHAN],
    output logic [idx_width(NCHUNKS)-1:0]        chunk_idx,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 last,
    output logic                                 done
);

    localparam int c_chunk_elems = VEC_LEN / NCHUNKS;
    localparam int c_cw          = c_chunk_elems * NBITS;
    localparam int c_iw          = idx_width(NCHUNKS);
    localparam int c_fw          = VEC_LEN * NBITS;
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(NCHUNKS - 1);

    if (!chunk_cfg_ok(VEC_LEN, NCHUNKS)) begin : g_cfg_error
        $error("vector_chunk_streamer: VEC_LEN must be a nonzero multiple of NCHUNKS");
    end

    stream_state_t   r_state;
    stream_state_t   w_state_nxt;
    logic [c_fw-1:0] w_flat      [NCHAN];
    logic [c_fw-1:0] r_cap       [NCHAN];
    logic [c_cw-1:0] w_sel_chunk [NCHAN];
    logic [c_cw-1:0] r_chunk     [NCHAN];
    logic [c_iw-1:0] r_idx;
    logic [c_iw-1:0] w_idx_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_capture;
    logic            w_chunk_load;

    // The chunk selected here is the one that will be on the output next cycle.
    for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
        vector_flattener #(
            .NBITS   (NBITS),
            .VEC_LEN (VEC_LEN)
        ) u_flat (
            .vec  (vec_in[ch]),
            .flat (w_flat[ch])
        );

        assign w_sel_chunk[ch] = r_cap[ch][int'(w_idx_nxt)*c_cw +: c_cw];
        assign chunk_out[ch]   = r_chunk[ch];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_valid_nxt  = r_valid;
        w_last_nxt   = r_last;
        w_done_nxt   = 1'b0;
        w_capture    = 1'b0;
        w_chunk_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_idx_nxt    = '0;
                w_valid_nxt  = 1'b1;
                w_last_nxt   = (NCHUNKS == 1);
                w_chunk_load = 1'b1;
                w_state_nxt  = STREAM;
            end
            STREAM: begin
                if (r_valid && out_ready) begin
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt    = r_idx + c_iw'(1);
                        w_last_nxt   = (w_idx_nxt == c_last_idx);
                        w_chunk_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            for (int ch = 0; ch < NCHAN; ch++) begin
                r_chunk[ch] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
            if (w_chunk_load) begin
                for (int ch = 0; ch < NCHAN; ch++) begin
                    r_chunk[ch] <= w_sel_chunk[ch];
                end
            end
        end
    end

    // Capture storage needs no reset: it is only read after a fresh capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int ch = 0; ch < NCHAN; ch++) begin
                r_cap[ch] <= w_flat[ch];
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign chunk_idx = r_idx;
    assign out_valid = r_valid;
    assign last      = r_last;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vector_chunk_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_chunk_streamer
//  Description : Self-checking bench for vector_chunk_streamer (4-chunk and 1-chunk builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_chunk_streamer;

    localparam int NBITS   = 8;
    localparam int VEC_LEN = 8;
    localparam int NCHAN   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NBITS-1:0] vec  [NCHAN][VEC_LEN];
    logic [NBITS-1:0] snap [NCHAN][VEC_LEN];

    logic        start4, ready4, busy4, valid4, last4, done4;
    logic [15:0] co4 [NCHAN];
    logic [1:0]  idx4;

    logic        start1, ready1, busy1, valid1, last1, done1;
    logic [63:0] co1 [NCHAN];
    logic [0:0]  idx1;

    int n_cmp  = 0;
    int n_fail = 0;

    vector_chunk_streamer #(
        .NBITS(NBITS), .VEC_LEN(VEC_LEN), .NCHAN(NCHAN), .NCHUNKS(4)
    ) u_dut4 (
        .clk(clk), .rst(rst), .vec_in(vec), .start(start4), .busy(busy4),
        .chunk_out(co4), .chunk_idx(idx4), .out_valid(valid4), .out_ready(ready4),
        .last(last4), .done(done4)
    );

    vector_chunk_streamer #(
        .NBITS(NBITS), .VEC_LEN(VEC_LEN), .NCHAN(NCHAN), .NCHUNKS(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .vec_in(vec), .start(start1), .busy(busy1),
        .chunk_out(co1), .chunk_idx(idx1), .out_valid(valid1), .out_ready(ready1),
        .last(last1), .done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Chunk c of a channel: its elements concatenated, lowest element in the LSBs.
    function automatic logic [63:0] model_chunk(input int ch, input int c, input int nchunks);
        int ce = VEC_LEN / nchunks;
        logic [63:0] v = '0;
        for (int e = 0; e < ce; e++) begin
            v |= 64'(snap[ch][c*ce+e]) << (NBITS*e);
        end
        return v;
    endfunction

    // mode 0: ch0[k]=k+1, ch1[k]=0x10+k; mode 1: random; otherwise all 0xFF.
    task automatic load_pattern(input int mode);
        for (int ch = 0; ch < NCHAN; ch++) begin
            for (int k = 0; k < VEC_LEN; k++) begin
                case (mode)
                    0:       vec[ch][k] = (ch == 0) ? 8'(k + 1) : 8'(8'h10 + k);
                    1:       vec[ch][k] = 8'($urandom);
                    default: vec[ch][k] = 8'hFF;
                endcase
            end
        end
    endtask

    task automatic check_idle_reset(input bit one, input string tag);
        chk({tag, "_busy"},  one ? busy1  : busy4,  0);
        chk({tag, "_valid"}, one ? valid1 : valid4, 0);
        chk({tag, "_last"},  one ? last1  : last4,  0);
        chk({tag, "_done"},  one ? done1  : done4,  0);
        chk({tag, "_idx"},   one ? {63'h0, idx1} : {62'h0, idx4}, 0);
        chk({tag, "_ch0"},   one ? co1[0] : {48'h0, co4[0]}, 0);
        chk({tag, "_ch1"},   one ? co1[1] : {48'h0, co4[1]}, 0);
    endtask

    task automatic start_dut(input bit one, input bit scramble);
        snap = vec;
        if (one) start1 = 1'b1; else start4 = 1'b1;
        step();
        start1 = 1'b0;
        start4 = 1'b0;
        if (scramble) load_pattern(2);
        chk("load_busy",  one ? busy1  : busy4,  1);
        chk("load_valid", one ? valid1 : valid4, 0);
        chk("load_done",  one ? done1  : done4,  0);
        step();
    endtask

    task automatic run_stream(input bit one, input int stall_beat, input int stall_len,
                              input bit rnd_ready, input int start_beat, input int rst_beat);
        int nch     = one ? 1 : 4;
        int beat    = 0;
        int cycles  = 0;
        int stalled = 0;
        bit pulsed  = 1'b0;
        bit rdy;
        while (beat < nch && cycles < 200) begin
            chk($sformatf("valid_b%0d", beat), one ? valid1 : valid4, 1);
            chk($sformatf("busy_b%0d", beat),  one ? busy1 : busy4, 1);
            chk($sformatf("idx_b%0d", beat),   one ? {63'h0, idx1} : {62'h0, idx4}, 64'(beat));
            chk($sformatf("last_b%0d", beat),  one ? last1 : last4, 64'(beat == nch - 1));
            chk($sformatf("done_b%0d", beat),  one ? done1 : done4, 0);
            chk($sformatf("ch0_b%0d", beat),   one ? co1[0] : {48'h0, co4[0]}, model_chunk(0, beat, nch));
            chk($sformatf("ch1_b%0d", beat),   one ? co1[1] : {48'h0, co4[1]}, model_chunk(1, beat, nch));
            if (beat == rst_beat) begin
                ready4 = 1'b0;
                ready1 = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_idle_reset(one, "midrst");
                for (int i = 0; i < 4; i++) begin
                    step();
                    chk("midrst_nodone", one ? done1 : done4, 0);
                    chk("midrst_novalid", one ? valid1 : valid4, 0);
                end
                return;
            end
            if (beat == start_beat && !pulsed) begin
                pulsed = 1'b1;
                if (one) start1 = 1'b1; else start4 = 1'b1;
            end
            if (beat == stall_beat && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (one) ready1 = rdy; else ready4 = rdy;
            step();
            cycles++;
            start4 = 1'b0;
            start1 = 1'b0;
            if (rdy) beat++;
        end
        chk("beats_completed", 64'(beat), 64'(nch));
        ready4 = 1'b0;
        ready1 = 1'b0;
        chk("end_done",  one ? done1  : done4,  1);
        chk("end_valid", one ? valid1 : valid4, 0);
        chk("end_last",  one ? last1  : last4,  0);
        chk("end_busy",  one ? busy1  : busy4,  0);
    endtask

    task automatic idle_after(input bit one);
        step();
        chk("idle_busy",  one ? busy1  : busy4,  0);
        chk("idle_valid", one ? valid1 : valid4, 0);
        chk("idle_done",  one ? done1  : done4,  0);
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        ready4 = 1'b0;
        ready1 = 1'b0;
        load_pattern(0);
        repeat (3) step();
        check_idle_reset(1'b0, "rst4");
        check_idle_reset(1'b1, "rst1");
        rst = 1'b0;
        step();

        // Basic stream, always ready
        start_dut(1'b0, 1'b0);
        run_stream(1'b0, -1, 0, 1'b0, -1, -1);

        // New start on the done cycle, with 5 cycles of back-pressure on beat 1
        start_dut(1'b0, 1'b0);
        run_stream(1'b0, 1, 5, 1'b0, -1, -1);
        idle_after(1'b0);

        // Source overwritten right after capture
        load_pattern(0);
        start_dut(1'b0, 1'b1);
        run_stream(1'b0, -1, 0, 1'b0, -1, -1);
        idle_after(1'b0);

        // Start pulsed mid-stream must be ignored
        load_pattern(1);
        start_dut(1'b0, 1'b0);
        run_stream(1'b0, -1, 0, 1'b0, 2, -1);
        idle_after(1'b0);

        // Reset at beat 2, then a normal stream
        load_pattern(0);
        start_dut(1'b0, 1'b0);
        run_stream(1'b0, -1, 0, 1'b0, -1, 2);
        load_pattern(1);
        start_dut(1'b0, 1'b0);
        run_stream(1'b0, -1, 0, 1'b0, -1, -1);
        idle_after(1'b0);

        // Random data with random back-pressure
        for (int it = 0; it < 8; it++) begin
            load_pattern(1);
            start_dut(1'b0, 1'b0);
            run_stream(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, -1, -1);
            repeat ($urandom_range(0, 2)) step();
        end

        // Single-chunk build
        load_pattern(0);
        step();
        start_dut(1'b1, 1'b0);
        run_stream(1'b1, -1, 0, 1'b0, -1, -1);
        idle_after(1'b1);
        for (int it = 0; it < 4; it++) begin
            load_pattern(1);
            start_dut(1'b1, 1'b0);
            run_stream(1'b1, 0, int'($urandom_range(0, 3)), 1'b1, -1, -1);
            idle_after(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
